// File: rtl/seq_pkg.sv
// seq_pkg: shared types and width helpers for the step sequencer.
// Holds the transport state enum, the pattern entry struct and idx_w().
package seq_pkg;

    // Widest pitch code a pattern entry can hold; PITCH_W must not exceed it.
    localparam int SEQ_PITCH_MAX = 8;

    typedef enum logic [1:0] {
        STOPPED = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2
    } seq_state_e;

    typedef struct packed {
        logic                     gate;
        logic [SEQ_PITCH_MAX-1:0] pitch;
    } step_entry_t;

    // Index width that stays >= 1 even for a single-entry dimension.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_core_if.sv
// seq_core_if: pattern edit bus from the button/encoder logic.
// Signals: valid, clear, track, step, pitch. master drives, slave (core) reads.
interface seq_core_if
    import seq_pkg::*;
#(
    parameter int NUM_TRACKS = 4,
    parameter int NUM_STEPS  = 16,
    parameter int PITCH_W    = 4
) ();

    localparam int TRK_W = idx_w(NUM_TRACKS);
    localparam int STP_W = idx_w(NUM_STEPS);

    logic               valid;
    logic               clear;
    logic [TRK_W-1:0]   track;
    logic [STP_W-1:0]   step;
    logic [PITCH_W-1:0] pitch;

    modport master (
        output valid, clear, track, step, pitch
    );

    modport slave (
        input valid, clear, track, step, pitch
    );

endinterface

// File: rtl/seq_tempo_timer.sv
// seq_tempo_timer: step period counter with P clamping, optional swing and
// strobe. Ports: clk, rst_n, en (count), clr (zero count), kick (force a
// strobe with clr), step_period, [swing_amt, odd, swing_on when SEQ_SWING_EN],
// wrap (comb terminal count while enabled), tick (registered strobe).
module seq_tempo_timer
    import seq_pkg::*;
#(
    parameter int PERIOD_W = 24
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                clr,
    input  logic                kick,
    input  logic [PERIOD_W-1:0] step_period,
`ifdef SEQ_SWING_EN
    input  logic [PERIOD_W-2:0] swing_amt,
    input  logic                odd,
    input  logic                swing_on,
`endif
    output logic                wrap,
    output logic                tick
);

    // One extra bit so P + swing cannot overflow.
    localparam int CW = PERIOD_W + 1;

    logic [CW-1:0] count;
    logic [CW-1:0] base;
    logic [CW-1:0] span;

    always_comb begin
        base = (step_period < PERIOD_W'(2)) ? CW'(2) : CW'(step_period);
        span = base;
`ifdef SEQ_SWING_EN
        if (swing_on) begin
            if (!odd) begin
                span = base + CW'(swing_amt);
            end else if (base >= CW'(swing_amt) + CW'(2)) begin
                span = base - CW'(swing_amt);
            end else begin
                span = CW'(2);
            end
        end
`endif
    end

    // >= rather than == so a period shrunk below the count ends the step now.
    assign wrap = en && (count >= span - CW'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
            tick  <= 1'b0;
        end else if (clr) begin
            count <= '0;
            tick  <= kick;
        end else begin
            tick <= wrap;
            if (wrap) begin
                count <= '0;
            end else if (en) begin
                count <= count + CW'(1);
            end
        end
    end

endmodule

// File: rtl/seq_core.sv
// seq_core: multi-track step sequencer with pattern store, transport FSM and
// step pointer. Ports: clk, rst_n (sync, active low), start/pause/stop pulses,
// step_period, pattern_last, edit (seq_core_if.slave), step_idx, step_strobe,
// gates, pitches, running. Define SEQ_SWING_EN to add the swing_amt input.
module seq_core
    import seq_pkg::*;
#(
    parameter int NUM_TRACKS = 4,
    parameter int NUM_STEPS  = 16,
    parameter int PITCH_W    = 4,
    parameter int PERIOD_W   = 24
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic                            pause,
    input  logic                            stop,
    input  logic [PERIOD_W-1:0]             step_period,
    input  logic [idx_w(NUM_STEPS)-1:0]     pattern_last,
`ifdef SEQ_SWING_EN
    input  logic [PERIOD_W-2:0]             swing_amt,
`endif
    seq_core_if.slave                       edit,
    output logic [idx_w(NUM_STEPS)-1:0]     step_idx,
    output logic                            step_strobe,
    output logic [NUM_TRACKS-1:0]           gates,
    output logic [NUM_TRACKS*PITCH_W-1:0]   pitches,
    output logic                            running
);

    localparam int TRK_W = idx_w(NUM_TRACKS);
    localparam int STP_W = idx_w(NUM_STEPS);
    localparam logic [TRK_W:0] TRK_LIM = (TRK_W+1)'(NUM_TRACKS);

    seq_state_e       state;
    step_entry_t      store [NUM_TRACKS][NUM_STEPS];
    logic             run_en;
    logic             tmr_kick;
    logic             tmr_clr;
    logic             wrap;
    logic             trk_ok;
    logic [STP_W-1:0] next_idx;

    // Stop beats start beats pause; start while running masks pause.
    assign run_en   = (state == RUNNING) && !stop && !(pause && !start);
    assign tmr_kick = (state == STOPPED) && start && !stop;
    assign tmr_clr  = stop || tmr_kick;

    assign next_idx = (step_idx >= pattern_last) ? '0
                                                 : step_idx + STP_W'(1);

    assign trk_ok = ({1'b0, edit.track} < TRK_LIM);

    seq_tempo_timer #(
        .PERIOD_W    (PERIOD_W)
    ) u_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (run_en),
        .clr         (tmr_clr),
        .kick        (tmr_kick),
        .step_period (step_period),
`ifdef SEQ_SWING_EN
        .swing_amt   (swing_amt),
        .odd         (step_idx[0]),
        .swing_on    (pattern_last != '0),
`endif
        .wrap        (wrap),
        .tick        (step_strobe)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= STOPPED;
            step_idx <= '0;
            running  <= 1'b0;
        end else if (stop) begin
            state    <= STOPPED;
            step_idx <= '0;
            running  <= 1'b0;
        end else begin
            unique case (state)
                STOPPED: begin
                    if (start) begin
                        state    <= RUNNING;
                        step_idx <= '0;
                        running  <= 1'b1;
                    end
                end
                RUNNING: begin
                    if (pause && !start) begin
                        state   <= PAUSED;
                        running <= 1'b0;
                    end
                    if (wrap) begin
                        step_idx <= next_idx;
                    end
                end
                PAUSED: begin
                    if (start) begin
                        state   <= RUNNING;
                        running <= 1'b1;
                    end
                end
                default: begin
                    state    <= STOPPED;
                    step_idx <= '0;
                    running  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int t = 0; t < NUM_TRACKS; t++) begin
                for (int s = 0; s < NUM_STEPS; s++) begin
                    store[t][s] <= '0;
                end
            end
        end else if (edit.valid && trk_ok) begin
            if (edit.clear) begin
                store[edit.track][edit.step].gate <= 1'b0;
            end else begin
                store[edit.track][edit.step].gate <=
                    ~store[edit.track][edit.step].gate;
                store[edit.track][edit.step].pitch <=
                    SEQ_PITCH_MAX'(edit.pitch);
            end
        end
    end

    always_comb begin
        gates   = '0;
        pitches = '0;
        for (int t = 0; t < NUM_TRACKS; t++) begin
            gates[t] = running && store[t][step_idx].gate;
            pitches[t*PITCH_W +: PITCH_W] =
                PITCH_W'(store[t][step_idx].pitch);
        end
    end

endmodule

// File: tb/tb_seq_core.sv
// tb_seq_core: directed scenario bench for seq_core.
// Each task drives one scenario and checks outputs inline.
module tb_seq_core;
    import seq_pkg::*;

    localparam int NT   = 4;
    localparam int NS   = 16;
    localparam int PW   = 4;
    localparam int PERW = 24;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic            pause;
    logic            stop;
    logic [PERW-1:0] step_period;
    logic [3:0]      pattern_last;
    logic [3:0]      step_idx;
    logic            step_strobe;
    logic [3:0]      gates;
    logic [15:0]     pitches;
    logic            running;
`ifdef SEQ_SWING_EN
    logic [PERW-2:0] swing_amt;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    seq_core_if #(
        .NUM_TRACKS (NT),
        .NUM_STEPS  (NS),
        .PITCH_W    (PW)
    ) edit_bus ();

    seq_core #(
        .NUM_TRACKS   (NT),
        .NUM_STEPS    (NS),
        .PITCH_W      (PW),
        .PERIOD_W     (PERW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .pause        (pause),
        .stop         (stop),
        .step_period  (step_period),
        .pattern_last (pattern_last),
`ifdef SEQ_SWING_EN
        .swing_amt    (swing_amt),
`endif
        .edit         (edit_bus),
        .step_idx     (step_idx),
        .step_strobe  (step_strobe),
        .gates        (gates),
        .pitches      (pitches),
        .running      (running)
    );

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic do_edit(input int trk, input int stp, input int p,
                           input logic clr);
        edit_bus.valid = 1'b1;
        edit_bus.clear = clr;
        edit_bus.track = 2'(trk);
        edit_bus.step  = 4'(stp);
        edit_bus.pitch = 4'(p);
        step_clk();
        edit_bus.valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step_clk();
        tests++;
        if (step_idx !== 4'd0) begin
            fails++;
            $display("FAIL reset_idx: got %0d want 0", step_idx);
        end
        tests++;
        if (step_strobe !== 1'b0) begin
            fails++;
            $display("FAIL reset_strobe: got %b want 0", step_strobe);
        end
        tests++;
        if (gates !== 4'h0) begin
            fails++;
            $display("FAIL reset_gates: got %h want 0", gates);
        end
        tests++;
        if (pitches !== 16'h0) begin
            fails++;
            $display("FAIL reset_pitches: got %h want 0", pitches);
        end
        tests++;
        if (running !== 1'b0) begin
            fails++;
            $display("FAIL reset_running: got %b want 0", running);
        end
        rst_n = 1'b1;
        step_clk();
    endtask

    task automatic test_edit_stopped();
        do_edit(2, 1, 5, 1'b0);
        do_edit(0, 0, 9, 1'b0);
        do_edit(0, 0, 9, 1'b0);
        do_edit(0, 0, 3, 1'b1);
        do_edit(1, 3, 12, 1'b0);
        do_edit(0, 2, 1, 1'b0);
        tests++;
        if (pitches !== 16'h0009) begin
            fails++;
            $display("FAIL edit_stop_pitch: got %h want 0009", pitches);
        end
        tests++;
        if (gates !== 4'h0) begin
            fails++;
            $display("FAIL edit_stop_gates: got %h want 0", gates);
        end
        tests++;
        if (step_idx !== 4'd0 || running !== 1'b0) begin
            fails++;
            $display("FAIL edit_stop_idx: got %0d/%b want 0/0",
                     step_idx, running);
        end
    endtask

    task automatic test_basic_run();
        logic [3:0]  g_tab [4];
        logic [15:0] p_tab [4];
        logic        exp_s;
        logic [3:0]  exp_i;
        g_tab = '{4'b0000, 4'b0100, 4'b0001, 4'b0010};
        p_tab = '{16'h0009, 16'h0500, 16'h0001, 16'h00C0};
        step_period  = 24'd4;
        pattern_last = 4'd3;
        start = 1'b1;
        step_clk();
        start = 1'b0;
        for (int c = 0; c <= 16; c++) begin
            if (c > 0) step_clk();
            exp_s = (c % 4 == 0);
            exp_i = 4'((c / 4) % 4);
            tests++;
            if (step_strobe !== exp_s) begin
                fails++;
                $display("FAIL run_strobe c=%0d: got %b want %b",
                         c, step_strobe, exp_s);
            end
            tests++;
            if (step_idx !== exp_i) begin
                fails++;
                $display("FAIL run_idx c=%0d: got %0d want %0d",
                         c, step_idx, exp_i);
            end
            tests++;
            if (gates !== g_tab[exp_i[1:0]]) begin
                fails++;
                $display("FAIL run_gates c=%0d: got %h want %h",
                         c, gates, g_tab[exp_i[1:0]]);
            end
            tests++;
            if (pitches !== p_tab[exp_i[1:0]]) begin
                fails++;
                $display("FAIL run_pitches c=%0d: got %h want %h",
                         c, pitches, p_tab[exp_i[1:0]]);
            end
            tests++;
            if (running !== 1'b1) begin
                fails++;
                $display("FAIL run_running c=%0d: got %b want 1",
                         c, running);
            end
        end
    endtask

    task automatic test_pause();
        repeat (9) step_clk();
        tests++;
        if (step_idx !== 4'd2 || step_strobe !== 1'b0) begin
            fails++;
            $display("FAIL pause_pre: got idx %0d strobe %b want 2/0",
                     step_idx, step_strobe);
        end
        pause = 1'b1;
        step_clk();
        pause = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tests++;
            if (step_idx !== 4'd2 || step_strobe !== 1'b0 ||
                running !== 1'b0 || gates !== 4'h0) begin
                fails++;
                $display("FAIL pause_hold k=%0d: got %0d/%b/%b/%h want 2/0/0/0",
                         k, step_idx, step_strobe, running, gates);
            end
            step_clk();
        end
        start = 1'b1;
        step_clk();
        start = 1'b0;
        tests++;
        if (running !== 1'b1 || step_strobe !== 1'b0 ||
            step_idx !== 4'd2 || gates !== 4'b0001) begin
            fails++;
            $display("FAIL resume: got %b/%b/%0d/%h want 1/0/2/1",
                     running, step_strobe, step_idx, gates);
        end
        for (int k = 1; k <= 3; k++) begin
            step_clk();
            tests++;
            if (step_strobe !== (k == 3)) begin
                fails++;
                $display("FAIL resume_strobe k=%0d: got %b want %b",
                         k, step_strobe, (k == 3));
            end
        end
        tests++;
        if (step_idx !== 4'd3) begin
            fails++;
            $display("FAIL resume_idx: got %0d want 3", step_idx);
        end
    endtask

    task automatic test_stop_start();
        stop  = 1'b1;
        start = 1'b1;
        step_clk();
        stop  = 1'b0;
        start = 1'b0;
        tests++;
        if (running !== 1'b0 || step_idx !== 4'd0 ||
            step_strobe !== 1'b0 || gates !== 4'h0) begin
            fails++;
            $display("FAIL stop_start: got %b/%0d/%b/%h want 0/0/0/0",
                     running, step_idx, step_strobe, gates);
        end
        repeat (3) step_clk();
        tests++;
        if (running !== 1'b0 || step_idx !== 4'd0 ||
            step_strobe !== 1'b0) begin
            fails++;
            $display("FAIL stop_hold: got %b/%0d/%b want 0/0/0",
                     running, step_idx, step_strobe);
        end
    endtask

    task automatic test_wrap_shrink();
        logic [3:0] i_tab [9];
        logic       s_tab [9];
        pattern_last = 4'd15;
        step_period  = 24'd4;
        start = 1'b1;
        step_clk();
        start = 1'b0;
        repeat (40) step_clk();
        tests++;
        if (step_idx !== 4'd10 || step_strobe !== 1'b1) begin
            fails++;
            $display("FAIL shrink_pre: got %0d/%b want 10/1",
                     step_idx, step_strobe);
        end
        pattern_last = 4'd5;
        repeat (3) step_clk();
        tests++;
        if (step_idx !== 4'd10 || step_strobe !== 1'b0) begin
            fails++;
            $display("FAIL shrink_hold: got %0d/%b want 10/0",
                     step_idx, step_strobe);
        end
        step_clk();
        tests++;
        if (step_idx !== 4'd0 || step_strobe !== 1'b1) begin
            fails++;
            $display("FAIL shrink_wrap: got %0d/%b want 0/1",
                     step_idx, step_strobe);
        end
        // period 0 clamps to 2; pattern_last drops to 0 after step 2
        step_period = 24'd0;
        s_tab = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        i_tab = '{4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 4'd0, 4'd0, 4'd0, 4'd0};
        for (int k = 0; k < 9; k++) begin
            step_clk();
            if (k == 3) pattern_last = 4'd0;
            tests++;
            if (step_strobe !== s_tab[k] || step_idx !== i_tab[k]) begin
                fails++;
                $display("FAIL fast_step k=%0d: got %0d/%b want %0d/%b",
                         k, step_idx, step_strobe, i_tab[k], s_tab[k]);
            end
        end
    endtask

    task automatic test_edit_live();
        do_edit(3, 0, 7, 1'b0);
        tests++;
        if (gates !== 4'b1000 || pitches !== 16'h7009) begin
            fails++;
            $display("FAIL live_toggle: got %h/%h want 8/7009",
                     gates, pitches);
        end
        tests++;
        if (step_idx !== 4'd0 || running !== 1'b1) begin
            fails++;
            $display("FAIL live_idx: got %0d/%b want 0/1",
                     step_idx, running);
        end
        do_edit(3, 0, 4, 1'b1);
        tests++;
        if (gates !== 4'h0 || pitches !== 16'h7009) begin
            fails++;
            $display("FAIL live_clear: got %h/%h want 0/7009",
                     gates, pitches);
        end
    endtask

    task automatic test_reset_midrun();
        rst_n = 1'b0;
        step_clk();
        tests++;
        if (step_strobe !== 1'b0 || running !== 1'b0 ||
            step_idx !== 4'd0) begin
            fails++;
            $display("FAIL midrst_ctl: got %b/%b/%0d want 0/0/0",
                     step_strobe, running, step_idx);
        end
        tests++;
        if (pitches !== 16'h0 || gates !== 4'h0) begin
            fails++;
            $display("FAIL midrst_store: got %h/%h want 0/0",
                     pitches, gates);
        end
        rst_n = 1'b1;
        step_clk();
    endtask

`ifdef SEQ_SWING_EN
    task automatic test_swing();
        logic       exp_s;
        logic [3:0] exp_i;
        step_period  = 24'd8;
        swing_amt    = 23'd2;
        pattern_last = 4'd3;
        start = 1'b1;
        step_clk();
        start = 1'b0;
        for (int c = 0; c <= 32; c++) begin
            if (c > 0) step_clk();
            exp_s = (c == 0 || c == 10 || c == 16 || c == 26 || c == 32);
            exp_i = (c < 10) ? 4'd0 : (c < 16) ? 4'd1 :
                    (c < 26) ? 4'd2 : (c < 32) ? 4'd3 : 4'd0;
            tests++;
            if (step_strobe !== exp_s || step_idx !== exp_i) begin
                fails++;
                $display("FAIL swing c=%0d: got %0d/%b want %0d/%b",
                         c, step_idx, step_strobe, exp_i, exp_s);
            end
        end
    endtask
`endif

    initial begin
        rst_n          = 1'b0;
        start          = 1'b0;
        pause          = 1'b0;
        stop           = 1'b0;
        step_period    = 24'd4;
        pattern_last   = 4'd3;
        edit_bus.valid = 1'b0;
        edit_bus.clear = 1'b0;
        edit_bus.track = '0;
        edit_bus.step  = '0;
        edit_bus.pitch = '0;
`ifdef SEQ_SWING_EN
        swing_amt      = '0;
`endif
        test_reset();
        test_edit_stopped();
        test_basic_run();
        test_pause();
        test_stop_start();
        test_wrap_shrink();
        test_edit_live();
        test_reset_midrun();
`ifdef SEQ_SWING_EN
        test_swing();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
